// File: rtl/fp_add_arb_pkg.sv
// Shared types for the fp_add arbiter: fp32 operand layout and sequencer states.
package fp_add_arb_pkg;
  localparam int FP_MAN_W = 23;
  localparam int FP_EXP_W = 8;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} arb_state_e;
endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester-side bus: per-requester operand handshakes and the broadcast result.
interface fp_add_arbiter_if
  import fp_add_arb_pkg::*;
#(
  parameter int NREQ = 4
) ();
  logic  [NREQ-1:0] req_valid;
  logic  [NREQ-1:0] req_ready;
  fp32_t [NREQ-1:0] req_a;
  fp32_t [NREQ-1:0] req_b;
  logic  [NREQ-1:0] rsp_valid;
  fp32_t            rsp_r;

  modport master (output req_valid, req_a, req_b, input req_ready, rsp_valid, rsp_r);
  modport slave  (input req_valid, req_a, req_b, output req_ready, rsp_valid, rsp_r);
endinterface

// File: rtl/fp_add_arb_tag_fifo.sv
// Ordered FIFO of requester tags for operations in flight inside fp_add.
module fp_add_arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined fp_add among NREQ requesters, with drain/flush.
// FP_ADD_ARB_PRIO_EN: requester 0 gets strict priority over the round-robin.
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  fp_add_arbiter_if.slave               rq,
  output logic                          fpu_src_valid,
  output logic [FP_MAN_W-1:0]           fpu_a_man,
  output logic [FP_EXP_W-1:0]           fpu_a_exp,
  output logic                          fpu_a_sign,
  output logic [FP_MAN_W-1:0]           fpu_b_man,
  output logic [FP_EXP_W-1:0]           fpu_b_exp,
  output logic                          fpu_b_sign,
  input  logic [FP_MAN_W-1:0]           fpu_r_man,
  input  logic [FP_EXP_W-1:0]           fpu_r_exp,
  input  logic                          fpu_r_sign,
  input  logic                          fpu_dst_valid,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_orphan
);
  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
`ifdef FP_ADD_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  arb_state_e      state, state_nxt;
  logic            done_entry;
  logic [TW-1:0]   rr_ptr, gnt_idx, tag_out, jj;
  logic [NREQ-1:0] gnt, rsp_valid_q;
  logic            found, credit_ok, hs, pop, fifo_empty, fifo_full;
  int              j;
  fp32_t           a_q, b_q, rsp_r_q;

  assign credit_ok = (inflight < CW'(MAX_INFLIGHT)) && !fifo_full;

  // First valid requester at or after rr_ptr; requester 0 is skipped in the
  // rotation when it already has strict priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    if (PRIO && rq.req_valid[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = TW'(j);
      if (!found && rq.req_valid[jj] && !(PRIO && j == 0)) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
    if (rst || state != ST_RUN || !credit_ok) gnt = '0;
  end

  assign rq.req_ready = gnt;
  assign hs           = |gnt;
  assign pop          = fpu_dst_valid && !fifo_empty;

  always_comb begin
    state_nxt  = state;
    done_entry = 1'b0;
    case (state)
      ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == '0 && !fpu_src_valid) begin
        state_nxt  = ST_DONE;
        done_entry = 1'b1;
      end
      ST_DONE:  if (!flush_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      flush_done    <= 1'b0;
      rr_ptr        <= '0;
      fpu_src_valid <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_valid_q   <= '0;
      rsp_r_q       <= '0;
      inflight      <= '0;
      err_orphan    <= 1'b0;
    end else begin
      state         <= state_nxt;
      flush_done    <= done_entry;
      fpu_src_valid <= hs;
      if (hs) begin
        rr_ptr <= (gnt_idx == TW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        a_q    <= rq.req_a[gnt_idx];
        b_q    <= rq.req_b[gnt_idx];
      end
      rsp_valid_q <= pop ? (NREQ'(1) << tag_out) : '0;
      if (pop) rsp_r_q <= {fpu_r_sign, fpu_r_exp, fpu_r_man};
      case ({hs, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      // A result with no owner is dropped; the flag stays until reset.
      if (fpu_dst_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  assign rq.rsp_valid = rsp_valid_q;
  assign rq.rsp_r     = rsp_r_q;
  assign {fpu_a_sign, fpu_a_exp, fpu_a_man} = a_q;
  assign {fpu_b_sign, fpu_b_exp, fpu_b_man} = b_q;

  fp_add_arb_tag_fifo #(.W(TW), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .pop   (pop),
    .din   (gnt_idx),
    .dout  (tag_out),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stand-in fp_add with adjustable latency, scoreboard of
// issued operations, directed scenarios followed by randomized traffic.
module tb_fp_add_arbiter;
  import fp_add_arb_pkg::*;
  localparam int NREQ = 4;
  localparam int MAXI = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NREQ(NREQ)) bus ();

  logic        fpu_src_valid, fpu_dst_valid, flush_req, flush_done, err_orphan;
  logic [22:0] fpu_a_man, fpu_b_man, fpu_r_man;
  logic [7:0]  fpu_a_exp, fpu_b_exp, fpu_r_exp;
  logic        fpu_a_sign, fpu_b_sign, fpu_r_sign;
  logic [3:0]  inflight;

  fp_add_arbiter #(.NREQ(NREQ), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .rq(bus),
    .fpu_src_valid(fpu_src_valid),
    .fpu_a_man(fpu_a_man), .fpu_a_exp(fpu_a_exp), .fpu_a_sign(fpu_a_sign),
    .fpu_b_man(fpu_b_man), .fpu_b_exp(fpu_b_exp), .fpu_b_sign(fpu_b_sign),
    .fpu_r_man(fpu_r_man), .fpu_r_exp(fpu_r_exp), .fpu_r_sign(fpu_r_sign),
    .fpu_dst_valid(fpu_dst_valid),
    .flush_req(flush_req), .flush_done(flush_done),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  function automatic logic [31:0] real2fp(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real fp2real(logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h0) return 0.0;
    e = {3'b0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] int2fp(int n);
    return real2fp(real'(n));
  endfunction

  // Stand-in fp_add: real-valued addition, latency 'lat' from src_valid to dst_valid.
  int          lat = 3;
  logic        inj = 1'b0;
  logic [15:0] pv;
  logic [31:0] pr [16];
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[14:0], fpu_src_valid};
      pr[0] <= real2fp(fp2real({fpu_a_sign, fpu_a_exp, fpu_a_man}) +
                       fp2real({fpu_b_sign, fpu_b_exp, fpu_b_man}));
      for (int i = 1; i < 16; i++) pr[i] <= pr[i-1];
    end
  end
  assign fpu_dst_valid = pv[lat-1] | inj;
  assign {fpu_r_sign, fpu_r_exp, fpu_r_man} = pr[lat-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] exp_ready(logic [NREQ-1:0] v, int ptr, int cnt);
    if (v == '0 || cnt >= MAXI) return '0;
`ifdef FP_ADD_ARB_PRIO_EN
    if (v[0]) return NREQ'(1);
`endif
    for (int k = 0; k < NREQ; k++) begin
      int jx;
      jx = (ptr + k) % NREQ;
`ifdef FP_ADD_ARB_PRIO_EN
      if (jx == 0) continue;
`endif
      if (v[jx]) return NREQ'(1) << jx;
    end
    return '0;
  endfunction

  // Scoreboard: issue order is response order; model credit = queue depth.
  typedef struct { int idx; logic [31:0] r; } exp_t;
  exp_t            sb[$];
  int              gq[$];
  int              ia[NREQ];
  int              ib[NREQ];
  int              mptr = 0;
  int              n_rsp = 0;
  bit              chk_rr = 1'b0;
  exp_t            me;
  logic [NREQ-1:0] mhs;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      mptr = 0;
    end else begin
      if (bus.rsp_valid != '0) begin
        n_rsp++;
        if (sb.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
        else begin
          me = sb.pop_front();
          chk("rsp_owner", 64'(bus.rsp_valid), 64'd1 << me.idx);
          chk("rsp_r", 64'(bus.rsp_r), 64'(me.r));
        end
      end
      chk("inflight", 64'(inflight), 64'(sb.size()));
      if (chk_rr) chk("req_ready", 64'(bus.req_ready), 64'(exp_ready(bus.req_valid, mptr, sb.size())));
      mhs = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NREQ; i++) if (mhs[i]) begin
        me.idx = i;
        me.r   = int2fp(ia[i] + ib[i]);
        sb.push_back(me);
        gq.push_back(i);
        mptr = (i + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, int a, int b);
    ia[i] = a;
    ib[i] = b;
    bus.req_a[i] = int2fp(a);
    bus.req_b[i] = int2fp(b);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(1, 100000), $urandom_range(1, 100000));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int t = 0;
    while ((inflight != '0 || pv != '0) && t < 200) begin
      step();
      t++;
    end
    step();
    chk(tag, 64'(t < 200), 64'd1);
  endtask

  int t, cnt, base;
  int fair_exp[8];

  initial begin
`ifdef FP_ADD_ARB_PRIO_EN
    fair_exp = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    flush_req = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin ia[i] = 0; ib[i] = 0; end
    bus.req_valid = '1;
    step();
    step();
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_src_valid", 64'(fpu_src_valid), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_outputs", 64'({flush_done, err_orphan, inflight}), 64'd0);
    chk("rst_operands", 64'({fpu_a_sign, fpu_a_exp, fpu_a_man, fpu_b_sign, fpu_b_exp, fpu_b_man}), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    step();

    // Single op from requester 2: 1.0 + 2.0.
    set_req(2, 1, 2);
    bus.req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'b0100);
    step();
    bus.req_valid = '0;
    chk("single_src_valid", 64'(fpu_src_valid), 64'd1);
    chk("single_a", 64'({fpu_a_sign, fpu_a_exp, fpu_a_man}), 64'h3F800000);
    chk("single_b", 64'({fpu_b_sign, fpu_b_exp, fpu_b_man}), 64'h40000000);
    step();
    chk("single_src_pulse", 64'(fpu_src_valid), 64'd0);
    t = 0;
    while (!fpu_dst_valid && t < 20) begin step(); t++; end
    chk("single_dst_seen", 64'(fpu_dst_valid), 64'd1);
    chk("single_rsp_not_early", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("single_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    chk("single_rsp_r", 64'(bus.rsp_r), 64'h40400000);
    step();
    chk("single_rsp_pulse", 64'(bus.rsp_valid), 64'd0);

    // Fairness: all requesters valid for 8 cycles from rr_ptr = 0.
    do_reset();
    chk_rr = 1'b1;
    gq.delete();
    base = n_rsp;
    rand_ops();
    bus.req_valid = '1;
    for (int c = 0; c < 8; c++) begin step(); rand_ops(); end
    bus.req_valid = '0;
    chk("fair_count", 64'(gq.size()), 64'd8);
    for (int k = 0; k < 8 && k < gq.size(); k++) chk("fair_grant", 64'(gq[k]), 64'(fair_exp[k]));
    wait_idle("fair_drain");
    chk("fair_rsp_count", 64'(n_rsp - base), 64'd8);

    // Credit limit with fp_add latency above MAX_INFLIGHT.
    lat = 12;
    set_req(1, 7, 9);
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 8; c++) step();
    chk("credit_inflight", 64'(inflight), 64'd8);
    chk("credit_ready_full", 64'(bus.req_ready), 64'd0);
    t = 0;
    while (!fpu_dst_valid && t < 30) begin step(); t++; end
    chk("credit_dst_seen", 64'(fpu_dst_valid), 64'd1);
    chk("credit_ready_at_pop", 64'(bus.req_ready), 64'd0);
    step();
    chk("credit_ready_after_pop", 64'(bus.req_ready), 64'b0010);
    step();
    bus.req_valid = '0;
    wait_idle("credit_drain");
    lat = 3;

    // Flush with three operations in flight.
    chk_rr = 1'b0;
    lat = 6;
    rand_ops();
    bus.req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) step();
    bus.req_valid = '0;
    chk("flush_inflight3", 64'(inflight), 64'd3);
    flush_req = 1'b1;
    step();
    bus.req_valid = '1;
    #1;
    chk("flush_no_grant", 64'(bus.req_ready), 64'd0);
    cnt = 0;
    t = 0;
    while (cnt < 3 && t < 40) begin
      step();
      t++;
      chk("flush_hold_ready", 64'(bus.req_ready), 64'd0);
      if (bus.rsp_valid != '0) cnt++;
    end
    chk("flush_rsp3", 64'(cnt), 64'd3);
    chk("flush_done_early", 64'(flush_done), 64'd0);
    step();
    chk("flush_done_pulse", 64'(flush_done), 64'd1);
    step();
    chk("flush_done_once", 64'(flush_done), 64'd0);
    chk("flush_done_ready", 64'(bus.req_ready), 64'd0);
    flush_req = 1'b0;
    step();
`ifdef FP_ADD_ARB_PRIO_EN
    chk("flush_resume", 64'(bus.req_ready), 64'b0001);
`else
    chk("flush_resume", 64'(bus.req_ready), 64'b0100);
`endif
    bus.req_valid = '0;
    wait_idle("flush_drain");
    lat = 3;

    // Result arriving with nothing in flight.
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("orphan_set", 64'(err_orphan), 64'd1);
    chk("orphan_no_rsp", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("orphan_sticky", 64'(err_orphan), 64'd1);

    // Reset with five operations in flight.
    lat = 10;
    set_req(3, 11, 22);
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) step();
    chk("midrst_inflight5", 64'(inflight), 64'd5);
    rst = 1'b1;
    #1;
    chk("midrst_inflight", 64'(inflight), 64'd0);
    chk("midrst_orphan", 64'(err_orphan), 64'd0);
    chk("midrst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    step();
    step();
    bus.req_valid = '0;
    rst = 1'b0;
    base = n_rsp;
    for (int c = 0; c < 25; c++) step();
    chk("midrst_no_spurious", 64'(n_rsp - base), 64'd0);
    chk("midrst_no_orphan", 64'(err_orphan), 64'd0);
    lat = 3;

`ifdef FP_ADD_ARB_PRIO_EN
    chk_rr = 1'b1;
    rand_ops();
    bus.req_valid = 4'b0011;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("prio_0", 64'(bus.req_ready), 64'b0001);
      step();
    end
    bus.req_valid = 4'b0010;
    #1;
    chk("prio_1", 64'(bus.req_ready), 64'b0010);
    step();
    bus.req_valid = '0;
    wait_idle("prio_drain");
`endif

    // Randomized traffic at several fp_add latencies.
    chk_rr = 1'b1;
    for (int blk = 0; blk < 3; blk++) begin
      lat = $urandom_range(1, 9);
      for (int c = 0; c < 100; c++) begin
        rand_ops();
        bus.req_valid = NREQ'($urandom);
        step();
      end
      bus.req_valid = '0;
      wait_idle("rand_drain");
      chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    end
    chk("final_orphan", 64'(err_orphan), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
